int_sequencer: RTL and testbench
================================

// Module: int_sequencer
// PURPOSE
//  Parametrised interrupt/T-cycle sequencer for the CPU core: generates the T-state counter and M-cycle strobe,
//  owns IME (with one-instruction EI delay, DI, RETI), HALT wake-up and a 5-M-cycle interrupt dispatch sequence.
//  Generalises the controller's fixed 5-source ints/ime/int_ack handling to N sources with priority and vector output.
//  Sits between the IE/IF registers and the controller; the controller consumes m_strobe, int_active and int_vec.
// PARAMETERS
//  N_INT      5      number of interrupt sources; bit 0 = highest priority
//  VEC_BASE   16'h40 vector address of source 0
//  VEC_STRIDE 8      byte distance between consecutive vectors
//  T_PER_M    4      T-states per M-cycle (>=2)
// PORTS
//  clk           in  1                   clock
//  reset         in  1                   asynchronous, active-high reset
//  cpu_en        in  1                   clock enable; all state frozen when low
//  ie            in  N_INT               interrupt enable mask (IE register)
//  if_req        in  N_INT               pending flags (IF register)
//  insn_boundary in  1                   current M-cycle is the last of an instruction (controller op_fetch point)
//  ei            in  1                   EI executing; sampled only on boundary m_strobe
//  di            in  1                   DI executing; sampled on any m_strobe
//  reti          in  1                   RETI executing; sampled on any m_strobe
//  halt_req      in  1                   HALT executing; sampled on boundary m_strobe
//  t             out $clog2(T_PER_M)     T-state counter
//  m_strobe      out 1                   cpu_en & (t == T_PER_M-1)
//  ime           out 1                   interrupt master enable
//  halted        out 1                   state == HALT
//  int_active    out 1                   state == DISPATCH
//  irq_take      out 1                   one-clk pulse on entry to DISPATCH
//  int_ack       out N_INT               one-hot one-clk pulse; clears the serviced IF bit
//  int_vec       out 16                  dispatch target; valid from the ack onward, held until next dispatch
//  d_cnt         out 3                   dispatch M-cycle index 0..4
// BEHAVIOUR
//  Reset: t=0, state RUN, ime=0, ei_arm=0, d_cnt=0, int_vec=0, all pulses 0. Reset mid-dispatch aborts, no ack.
//  t: increments on cpu_en, wraps T_PER_M-1 -> 0. Every transition below happens only on m_strobe.
//  pending = ie & if_req; winner = lowest set index of pending.
//  IME:
//   - ei at boundary: ei_arm<=1. At the next boundary strobe: ime<=1, ei_arm<=0. The interrupt check at that strobe
//     uses old ime=0, so one more instruction always executes.
//   - di: ime<=0, ei_arm<=0 at once. di and ei together: di wins.
//   - reti: ime<=1 at once, no delay.
//   - dispatch entry: ime<=0, ei_arm<=0.
//  States:
//   - RUN -> DISPATCH: boundary strobe & ime & |pending; irq_take pulses; d_cnt<=0. Has priority over halt_req/ei.
//   - RUN -> HALT: boundary strobe & halt_req & no dispatch.
//   - HALT: exits on the first strobe with |pending (ime irrelevant). ime=1 -> DISPATCH (irq_take); ime=0 -> RUN.
//   - DISPATCH: d_cnt increments each strobe. On the strobe ending d_cnt==2, winner is re-evaluated:
//     - pending!=0: int_ack<=onehot(winner), int_vec<=VEC_BASE+winner*VEC_STRIDE (16-bit, truncating).
//     - pending==0 (cancelled): no ack, int_vec<=16'h0000.
//     On the strobe ending d_cnt==4: -> RUN, d_cnt<=0.
//  Pulses last exactly one clk (the strobe clk). No ack or vector outside DISPATCH. IF changes after the ack are ignored.
// TESTING
//  - ime=1, ie=5'h1F, if_req=5'h14 at boundary: irq_take, int_ack=5'h04 at 3rd strobe, int_vec=16'h0050, 5 M-cycles.
//  - ei at boundary N, if_req=ie=1 held: no dispatch at N+1, ime rises at N+1, dispatch at N+2.
//  - ei+di same strobe: ime stays 0, ei_arm 0. reti: ime=1 at the same strobe.
//  - halt_req, ime=0, then if_req=ie=5'h02: halted drops on the next strobe, state RUN, no irq_take, ime=0.
//  - dispatch start, then ie cleared before 3rd strobe: int_ack=0, int_vec=16'h0000; RUN after 5 M-cycles.
//  - cpu_en low 10 clks mid-dispatch: t, d_cnt, outputs frozen. Reset at d_cnt=1: all outputs return to reset values.

Source files
------------

// File: rtl/int_sequencer.sv
// Interrupt/T-cycle sequencer: T-state counter, M-cycle strobe, IME with EI delay, HALT wake-up, 5-M-cycle dispatch.
// Latency: state changes only at the m_strobe clock edge; irq_take/int_ack are combinational pulses during that clock.
// Backpressure: cpu_en_i low freezes every register, and m_strobe_o plus all pulses stay low.
// Ports: clk_i/reset_i (async, active-high), cpu_en_i, ie_i/if_req_i (IE/IF registers), insn_boundary_i,
//        ei_i/di_i/reti_i/halt_req_i (decoded instruction controls) -> t_o, m_strobe_o, ime_o, halted_o,
//        int_active_o, irq_take_o, int_ack_o (one-hot IF clear), int_vec_o, d_cnt_o.
module int_sequencer #(
  parameter int unsigned N_INT      = 5,
  parameter logic [15:0] VEC_BASE   = 16'h0040,
  parameter int unsigned VEC_STRIDE = 8,
  parameter int unsigned T_PER_M    = 4,
  localparam int unsigned TW        = (T_PER_M > 1) ? $clog2(T_PER_M) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cpu_en_i,
  input  logic [N_INT-1:0] ie_i,
  input  logic [N_INT-1:0] if_req_i,
  input  logic             insn_boundary_i,
  input  logic             ei_i,
  input  logic             di_i,
  input  logic             reti_i,
  input  logic             halt_req_i,
  output logic [TW-1:0]    t_o,
  output logic             m_strobe_o,
  output logic             ime_o,
  output logic             halted_o,
  output logic             int_active_o,
  output logic             irq_take_o,
  output logic [N_INT-1:0] int_ack_o,
  output logic [15:0]      int_vec_o,
  output logic [2:0]       d_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HALT     = 2'd1,
    ST_DISPATCH = 2'd2
  } state_e;

  localparam logic [TW-1:0] T_LAST = TW'(T_PER_M - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic            ime_q, ime_d;
  logic            ei_arm_q, ei_arm_d;
  logic [2:0]      d_cnt_q, d_cnt_d;
  logic [15:0]     int_vec_q, int_vec_d;

  logic            m_strobe;
  logic            irq_take;
  logic            take;
  logic [N_INT-1:0] int_ack;
  logic [N_INT-1:0] pending;
  logic [N_INT-1:0] win_onehot;
  logic [15:0]     win_idx;
  logic [15:0]     win_vec;

  assign m_strobe = cpu_en_i && (t_q == T_LAST);
  assign pending  = ie_i & if_req_i;

  // Two's-complement trick isolates the lowest set bit, i.e. the highest-priority source.
  assign win_onehot = pending & (~pending + N_INT'(1));

  always_comb begin
    win_idx = 16'd0;
    for (int i = int'(N_INT) - 1; i >= 0; i--) begin
      if (pending[i]) win_idx = 16'(i);
    end
  end

  // 16-bit wraparound is intended for large vector tables.
  assign win_vec = VEC_BASE + win_idx * 16'(VEC_STRIDE);

  always_comb begin
    t_d = t_q;
    if (cpu_en_i) t_d = (t_q == T_LAST) ? '0 : t_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    ime_d     = ime_q;
    ei_arm_d  = ei_arm_q;
    d_cnt_d   = d_cnt_q;
    int_vec_d = int_vec_q;
    irq_take  = 1'b0;
    int_ack   = '0;
    take      = 1'b0;

    if (m_strobe) begin
      case (state_q)
        ST_RUN: begin
          if (insn_boundary_i) begin
            // The check uses the old ime, so an EI promoted on this strobe still lets one instruction run.
            if (ime_q && |pending) begin
              take = 1'b1;
            end else begin
              if (ei_arm_q) begin
                ime_d    = 1'b1;
                ei_arm_d = 1'b0;
              end
              if (ei_i)       ei_arm_d = 1'b1;
              if (halt_req_i) state_d  = ST_HALT;
            end
          end
        end
        ST_HALT: begin
          if (|pending) begin
            if (ime_q) take = 1'b1;
            else       state_d = ST_RUN;
          end
        end
        ST_DISPATCH: begin
          // Winner is re-evaluated at the third M-cycle; a vanished request cancels to vector 0.
          if (d_cnt_q == 3'd2) begin
            if (|pending) begin
              int_ack   = win_onehot;
              int_vec_d = win_vec;
            end else begin
              int_vec_d = 16'h0000;
            end
          end
          if (d_cnt_q == 3'd4) begin
            state_d = ST_RUN;
            d_cnt_d = 3'd0;
          end else begin
            d_cnt_d = d_cnt_q + 3'd1;
          end
        end
        default: state_d = ST_RUN;
      endcase

      if (reti_i) ime_d = 1'b1;
      if (di_i) begin
        ime_d    = 1'b0;
        ei_arm_d = 1'b0;
      end
      // Dispatch entry overrides any concurrent IME update.
      if (take) begin
        state_d  = ST_DISPATCH;
        d_cnt_d  = 3'd0;
        ime_d    = 1'b0;
        ei_arm_d = 1'b0;
        irq_take = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_RUN;
      t_q       <= '0;
      ime_q     <= 1'b0;
      ei_arm_q  <= 1'b0;
      d_cnt_q   <= 3'd0;
      int_vec_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      ime_q     <= ime_d;
      ei_arm_q  <= ei_arm_d;
      d_cnt_q   <= d_cnt_d;
      int_vec_q <= int_vec_d;
    end
  end

  assign t_o          = t_q;
  assign m_strobe_o   = m_strobe;
  assign ime_o        = ime_q;
  assign halted_o     = (state_q == ST_HALT);
  assign int_active_o = (state_q == ST_DISPATCH);
  assign irq_take_o   = irq_take;
  assign int_ack_o    = int_ack;
  assign int_vec_o    = int_vec_q;
  assign d_cnt_o      = d_cnt_q;

endmodule

// File: tb/tb_int_sequencer.sv
module tb_int_sequencer;
  localparam int N   = 5;
  localparam int TPM = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_en;
  logic [N-1:0] ie, if_req;
  logic         bnd, ei, di, reti, halt;
  logic [1:0]   t_o;
  logic         m_strobe_o, ime_o, halted_o, int_active_o, irq_take_o;
  logic [N-1:0] int_ack_o;
  logic [15:0]  int_vec_o;
  logic [2:0]   d_cnt_o;

  always #5 clk = ~clk;

  int_sequencer #(.N_INT(N), .VEC_BASE(16'h0040), .VEC_STRIDE(8), .T_PER_M(TPM)) dut (
    .clk_i(clk), .reset_i(reset), .cpu_en_i(cpu_en), .ie_i(ie), .if_req_i(if_req),
    .insn_boundary_i(bnd), .ei_i(ei), .di_i(di), .reti_i(reti), .halt_req_i(halt),
    .t_o(t_o), .m_strobe_o(m_strobe_o), .ime_o(ime_o), .halted_o(halted_o),
    .int_active_o(int_active_o), .irq_take_o(irq_take_o), .int_ack_o(int_ack_o),
    .int_vec_o(int_vec_o), .d_cnt_o(d_cnt_o)
  );

  // Expected observation for one M-cycle strobe.
  typedef struct {
    bit          take;
    logic [4:0]  ack;
    bit          ime;
    bit          halted;
    bit          active;
    int          dcnt;
    logic [15:0] vec;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: 0 = running, 1 = halted, 2 = dispatching (step = M-cycle within dispatch).
  int          m_mode, m_step;
  bit          m_ime, m_arm;
  logic [15:0] m_vec;
  logic [4:0]  tb_if;   // the IF register as seen by the core; acks clear bits

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_step = 0; m_ime = 0; m_arm = 0; m_vec = 16'h0000;
  endtask

  // Assert reset at a quiet point, check reset values, release after the next posedge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_t", 32'(t_o), 0);
    chk("rst_ime", 32'(ime_o), 0);
    chk("rst_halted", 32'(halted_o), 0);
    chk("rst_active", 32'(int_active_o), 0);
    chk("rst_dcnt", 32'(d_cnt_o), 0);
    chk("rst_vec", 32'(int_vec_o), 0);
    chk("rst_take", 32'(irq_take_o), 0);
    chk("rst_ack", 32'(int_ack_o), 0);
    chk("rst_strobe", 32'(m_strobe_o), 0);
    @(posedge clk); #2;
    reset = 1'b0;
    model_reset();
  endtask

  // One M-cycle with the given inputs; 'set' ORs new requests into IF; 'stall' inserts
  // cpu_en-low clocks just before the strobe clock.
  task automatic mc(input logic [4:0] ie_v, input logic [4:0] set, input bit b, input bit e_i,
                    input bit d_i, input bit r_i, input bit h_i, input int stall);
    exp_t        e;
    logic [4:0]  pend;
    int          w;
    bit          take;
    int          pre_step;
    bit          pre_ime;
    logic [15:0] pre_vec;

    tb_if    = tb_if | set;
    pend     = ie_v & tb_if;
    w        = -1;
    for (int i = N - 1; i >= 0; i--) if (pend[i]) w = i;
    pre_step = m_step; pre_ime = m_ime; pre_vec = m_vec;
    e.take   = 0; e.ack = 5'h00; take = 0;

    if (m_mode == 0) begin
      if (b) begin
        if (m_ime && pend != 0) take = 1;
        else begin
          if (m_arm) begin m_ime = 1; m_arm = 0; end
          if (e_i) m_arm = 1;
          if (h_i) m_mode = 1;
        end
      end
    end else if (m_mode == 1) begin
      if (pend != 0) begin
        if (m_ime) take = 1;
        else m_mode = 0;
      end
    end else begin
      if (m_step == 2) begin
        if (w >= 0) begin
          e.ack = 5'(1 << w);
          m_vec = 16'(64 + w * 8);
        end else m_vec = 16'h0000;
      end
      if (m_step == 4) begin m_mode = 0; m_step = 0; end
      else m_step++;
    end
    if (r_i) m_ime = 1;
    if (d_i) begin m_ime = 0; m_arm = 0; end
    if (take) begin m_mode = 2; m_step = 0; m_ime = 0; m_arm = 0; e.take = 1; end

    e.ime = m_ime; e.halted = (m_mode == 1); e.active = (m_mode == 2);
    e.dcnt = m_step; e.vec = m_vec;
    q.push_back(e);

    ie = ie_v; if_req = tb_if; bnd = b; ei = e_i; di = d_i; reti = r_i; halt = h_i;
    for (int c = 0; c < TPM; c++) begin
      if (c == TPM - 1 && stall > 0) begin
        cpu_en = 1'b0;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk("stall_t", 32'(t_o), 32'(TPM - 1));
          chk("stall_strobe", 32'(m_strobe_o), 0);
          chk("stall_dcnt", 32'(d_cnt_o), 32'(pre_step));
          chk("stall_ime", 32'(ime_o), 32'(pre_ime));
          chk("stall_vec", 32'(int_vec_o), 32'(pre_vec));
          @(posedge clk); #2;
        end
        cpu_en = 1'b1;
      end
      @(negedge clk);
      chk("t", 32'(t_o), 32'(c));
      chk("m_strobe", 32'(m_strobe_o), 32'(c == TPM - 1));
      @(posedge clk); #2;
    end
    tb_if = tb_if & ~e.ack;
  endtask

  // Monitor: pops one expectation per strobe; pulses checked during the strobe clock,
  // registered outputs just after its edge.
  always @(negedge clk) begin
    if (!reset && m_strobe_o) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe: strobe seen with no expectation queued at %0t", $time);
      end else begin
        mon_e = q.pop_front();
        chk("irq_take", 32'(irq_take_o), 32'(mon_e.take));
        chk("int_ack", 32'(int_ack_o), 32'(mon_e.ack));
        @(posedge clk); #1;
        chk("ime", 32'(ime_o), 32'(mon_e.ime));
        chk("halted", 32'(halted_o), 32'(mon_e.halted));
        chk("int_active", 32'(int_active_o), 32'(mon_e.active));
        chk("d_cnt", 32'(d_cnt_o), 32'(mon_e.dcnt));
        chk("int_vec", 32'(int_vec_o), 32'(mon_e.vec));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    cpu_en = 1'b1; ie = '0; if_req = '0; bnd = 0; ei = 0; di = 0; reti = 0; halt = 0;
    tb_if = 5'h00;
    model_reset();
    do_reset();

    // Basic dispatch: priority picks source 2 of 5'h14, vector 0x50.
    mc(5'h00, 5'h00, 1, 0, 0, 1, 0, 0);            // reti: ime on at once
    mc(5'h1F, 5'h14, 1, 0, 0, 0, 0, 0);            // take
    repeat (4) mc(5'h1F, 5'h00, 0, 0, 0, 0, 0, 0); // ack at 3rd strobe
    tb_if = 5'h00;

    // EI delay: no dispatch at N+1, ime rises at N+1, dispatch at N+2.
    mc(5'h00, 5'h00, 1, 0, 1, 0, 0, 0);            // di
    mc(5'h01, 5'h01, 1, 1, 0, 0, 0, 0);            // ei
    mc(5'h01, 5'h00, 1, 0, 0, 0, 0, 0);
    mc(5'h01, 5'h00, 1, 0, 0, 0, 0, 0);
    repeat (4) mc(5'h01, 5'h00, 0, 0, 0, 0, 0, 0);

    // EI and DI together: DI wins and nothing stays armed.
    mc(5'h00, 5'h00, 1, 1, 1, 0, 0, 0);
    mc(5'h00, 5'h00, 1, 0, 0, 0, 0, 0);
    mc(5'h00, 5'h00, 1, 0, 0, 0, 0, 0);

    // HALT with ime=0 wakes to RUN without dispatch.
    mc(5'h00, 5'h00, 1, 0, 0, 0, 1, 0);
    mc(5'h00, 5'h00, 0, 0, 0, 0, 0, 0);
    mc(5'h02, 5'h02, 0, 0, 0, 0, 0, 0);
    mc(5'h00, 5'h00, 1, 0, 0, 0, 0, 0);
    tb_if = 5'h00;

    // Cancelled dispatch: IE cleared before the 3rd strobe.
    mc(5'h00, 5'h00, 1, 0, 0, 1, 0, 0);
    mc(5'h1F, 5'h08, 1, 0, 0, 0, 0, 0);
    repeat (4) mc(5'h00, 5'h00, 0, 0, 0, 0, 0, 0);
    tb_if = 5'h00;

    // cpu_en low for 10 clocks mid-dispatch.
    mc(5'h00, 5'h00, 1, 0, 0, 1, 0, 0);
    mc(5'h10, 5'h10, 1, 0, 0, 0, 0, 0);
    mc(5'h10, 5'h00, 0, 0, 0, 0, 0, 10);
    repeat (3) mc(5'h10, 5'h00, 0, 0, 0, 0, 0, 0);
    tb_if = 5'h00;

    // Reset at d_cnt=1 aborts the dispatch.
    mc(5'h00, 5'h00, 1, 0, 0, 1, 0, 0);
    mc(5'h04, 5'h04, 1, 0, 0, 0, 0, 0);
    mc(5'h04, 5'h00, 0, 0, 0, 0, 0, 0);
    do_reset();
    tb_if = 5'h00;

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      logic [4:0] ie_r, set_r;
      ie_r  = 5'($urandom);
      set_r = ($urandom_range(0, 3) == 0) ? 5'($urandom & $urandom) : 5'h00;
      mc(ie_r, set_r, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
         $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
         ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
